// File: rtl/opamp_ctrl_pkg.sv
// Shared types and defaults for the opamp offset-trim controller.
//   state_t            : calibration FSM state encoding
//   TRIM_W_DEF         : default trim DAC code width
//   SETTLE_CYCLES_DEF  : default analog settle wait per step, in clk cycles
package opamp_ctrl_pkg;

  localparam int TRIM_W_DEF        = 6;
  localparam int SETTLE_CYCLES_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    TEST   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
//   clk : destination clock, rising edge
//   rst : asynchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/opamp_trim_ctrl.sv
// Successive-approximation offset-trim controller for an opamp.
// While calibrating, the opamp is put in open-loop comparator mode (inputs
// shorted) and its output cmp_in tells whether the current trial code is at
// or below the zero-offset point. One bit is resolved per step, MSB first.
//
// Ports:
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : calibration request, level-sampled in IDLE
//   cmp_in     : opamp output used as comparator, asynchronous to clk
//   ovr_load   : (OPAMP_TRIM_OVERRIDE_EN only) load ovr_code in IDLE
//   ovr_code   : (OPAMP_TRIM_OVERRIDE_EN only) code loaded by ovr_load
//   trim_code  : offset-trim DAC code driven to the opamp
//   cal_mode   : high = opamp in comparator configuration
//   busy       : calibration in progress
//   done       : one-cycle pulse at calibration end
//   err        : sticky, result saturated at all-zeros or all-ones
//
// Build option: define OPAMP_TRIM_OVERRIDE_EN to add the manual override
// load path (ovr_load / ovr_code).
module opamp_trim_ctrl
  import opamp_ctrl_pkg::*;
#(
  parameter int TRIM_W        = TRIM_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp_in,
`ifdef OPAMP_TRIM_OVERRIDE_EN
  input  logic              ovr_load,
  input  logic [TRIM_W-1:0] ovr_code,
`endif
  output logic [TRIM_W-1:0] trim_code,
  output logic              cal_mode,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int BIT_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_MSB  = BIT_W'(TRIM_W - 1);
  localparam logic [TRIM_W-1:0] MIDSCALE = TRIM_W'(1) << (TRIM_W - 1);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [TRIM_W-1:0]   r_trim;
  logic                r_err;

  logic                w_cmp_s;
  logic                w_busy;
  logic                w_done;
  logic                w_cnt_zero;
  logic [TRIM_W-1:0]   w_onehot;
  logic [TRIM_W-1:0]   w_resolved;
  logic                w_sat;

  sync_2ff u_sync_cmp (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (w_cmp_s)
  );

  assign w_cnt_zero = (r_cnt == '0);
  assign w_onehot   = TRIM_W'(1) << r_bit;
  // Trial bit is kept when the comparator says the trial code is not too high.
  assign w_resolved = w_cmp_s ? r_trim : (r_trim & ~w_onehot);
  assign w_sat      = (w_resolved == '0) || (w_resolved == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = SETTLE;
      end
      SETTLE: begin
        w_busy = 1'b1;
        if (w_cnt_zero) w_next = TEST;
      end
      TEST: begin
        w_busy = 1'b1;
        if (w_cnt_zero) w_next = SAMPLE;
      end
      SAMPLE: begin
        w_busy = 1'b1;
        w_next = (r_bit == '0) ? DONE : TEST;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Settle counter: reloaded on each state change, then counts down and
  // holds at zero, so SETTLE and TEST each last exactly SETTLE_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= CNT_LOAD;
    end else if (!w_cnt_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // SAR register. r_trim is the code on the DAC at all times, so during
  // TEST/SAMPLE it already holds the trial bit and stays stable while the
  // comparator result travels through the synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trim <= MIDSCALE;
      r_bit  <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_trim <= '0;
            r_err  <= 1'b0;
            r_bit  <= BIT_MSB;
          end
`ifdef OPAMP_TRIM_OVERRIDE_EN
          else if (ovr_load) begin
            r_trim <= ovr_code;
            r_err  <= 1'b0;
          end
`endif
        end
        SETTLE: begin
          if (w_cnt_zero) r_trim <= r_trim | w_onehot;
        end
        SAMPLE: begin
          if (r_bit == '0) begin
            r_trim <= w_resolved;
            // Flag lands together with the done pulse.
            r_err  <= w_sat;
          end else begin
            r_trim <= w_resolved | (w_onehot >> 1);
            r_bit  <= r_bit - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign trim_code = r_trim;
  assign busy      = w_busy;
  assign cal_mode  = w_busy;
  assign done      = w_done;
  assign err       = r_err;

endmodule

// File: tb/tb_opamp_trim_ctrl.sv
module tb_opamp_trim_ctrl;

  localparam int TW  = 6;
  localparam int SC  = 4;
  localparam int LAT = SC + TW * (SC + 1) + 1;  // 35
  localparam int MAX_WAIT = 80;

  logic          clk;
  logic          rst;
  logic          start;
  logic          cmp_in;
  logic [TW-1:0] trim_code;
  logic          cal_mode;
  logic          busy;
  logic          done;
  logic          err;
`ifdef OPAMP_TRIM_OVERRIDE_EN
  logic          ovr_load;
  logic [TW-1:0] ovr_code;
`endif

  // 0: comparator high while trim_code <= thr, 1: tied high, 2: tied low
  int cmp_mode;
  int thr;
  // Extra pulse during a running calibration: kind 0 = start, 1 = ovr_load
  int pulse_at;
  int pulse_kind;

  typedef struct {
    logic [TW-1:0] code;
    logic          err;
    int            lat;
  } exp_t;
  exp_t sb[$];

  int passed;
  int total;
  int failed;

  opamp_trim_ctrl #(
    .TRIM_W        (TW),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmp_in    (cmp_in),
`ifdef OPAMP_TRIM_OVERRIDE_EN
    .ovr_load  (ovr_load),
    .ovr_code  (ovr_code),
`endif
    .trim_code (trim_code),
    .cal_mode  (cal_mode),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    cmp_in = 1'b0;
    case (cmp_mode)
      1:       cmp_in = 1'b1;
      2:       cmp_in = 1'b0;
      default: cmp_in = (int'(trim_code) <= thr);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t sar_model(input int mode, input int t);
    exp_t e;
    int code;
    code = 0;
    for (int b = TW - 1; b >= 0; b--) begin
      int trial;
      bit keep;
      trial = code | (1 << b);
      keep  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (trial <= t);
      if (keep) code = trial;
    end
    e.code = TW'(code);
    e.err  = (code == 0) || (code == (1 << TW) - 1);
    e.lat  = LAT;
    return e;
  endfunction

  // Cycle n is the n-th clock period after the edge that samples start;
  // each cycle is observed 1 time unit after its opening edge.
  task automatic run_cal(input string tag);
    exp_t e;
    int   n;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    chk({tag, "_busy_first"}, 32'(busy), 32'd1);
    chk({tag, "_calmode_first"}, 32'(cal_mode), 32'd1);
    while (!done && n < MAX_WAIT) begin
      if (n == pulse_at) begin
        if (pulse_kind == 0) start = 1'b1;
`ifdef OPAMP_TRIM_OVERRIDE_EN
        else ovr_load = 1'b1;
`endif
      end
      @(posedge clk);
      #1;
      start = 1'b0;
`ifdef OPAMP_TRIM_OVERRIDE_EN
      ovr_load = 1'b0;
`endif
      n++;
    end
    e = sb.pop_front();
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_latency"}, 32'(n), 32'(e.lat));
      chk({tag, "_code"}, 32'(trim_code), 32'(e.code));
      chk({tag, "_err"}, 32'(err), 32'(e.err));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    end
    pulse_at = -1;
  endtask

  initial begin
    int done_seen;
    passed = 0; total = 0; failed = 0;
    pulse_at = -1; pulse_kind = 0;
    cmp_mode = 0; thr = 37;
    start = 1'b0;
`ifdef OPAMP_TRIM_OVERRIDE_EN
    ovr_load = 1'b0;
    ovr_code = '0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_trim", 32'(trim_code), 32'd32);
    chk("rst_calmode", 32'(cal_mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Nominal calibration, threshold 37
    sb.push_back(sar_model(0, 37));
    run_cal("thr37");
    repeat (5) @(posedge clk);
    #1;
    chk("hold_idle", 32'(trim_code), 32'd37);

    // Saturation high and low
    cmp_mode = 1;
    sb.push_back(sar_model(1, 0));
    run_cal("tie1");
    cmp_mode = 2;
    sb.push_back(sar_model(2, 0));
    run_cal("tie0");
    repeat (4) @(posedge clk);
    #1;
    chk("err_sticky", 32'(err), 32'd1);

    // New start clears the flag
    cmp_mode = 0; thr = 37;
    sb.push_back(sar_model(0, 37));
    run_cal("clear_err");

    // Different threshold
    thr = 20;
    sb.push_back(sar_model(0, 20));
    run_cal("thr20");

    // start re-pulsed mid-calibration is ignored
    thr = 37;
    pulse_kind = 0; pulse_at = 10;
    sb.push_back(sar_model(0, 37));
    run_cal("retrig");

    // Abort by reset during TEST of bit 3 (cycles 15..18)
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_trim", 32'(trim_code), 32'd32);
    chk("abort_calmode", 32'(cal_mode), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("abort_idle_trim", 32'(trim_code), 32'd32);

`ifdef OPAMP_TRIM_OVERRIDE_EN
    @(negedge clk);
    ovr_code = 6'd12;
    ovr_load = 1'b1;
    @(posedge clk);
    #1;
    ovr_load = 1'b0;
    chk("ovr_idle_load", 32'(trim_code), 32'd12);
    pulse_kind = 1; pulse_at = 8;
    sb.push_back(sar_model(0, 37));
    run_cal("ovr_busy");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
